// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vend_pkg
//  Brief    : Shared types and constants for the vending transaction block.
//  Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam int CREDIT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] COIN_5   = 2'b00;
    localparam logic [1:0] COIN_10  = 2'b01;
    localparam logic [1:0] COIN_25  = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    localparam logic [CREDIT_W-1:0] COIN_5_VAL  = 8'd5;
    localparam logic [CREDIT_W-1:0] COIN_10_VAL = 8'd10;
    localparam logic [CREDIT_W-1:0] COIN_25_VAL = 8'd25;

    localparam logic [1:0] PROD1     = 2'b00;
    localparam logic [1:0] PROD2     = 2'b01;
    localparam logic [1:0] PROD3     = 2'b10;
    localparam logic [1:0] PROD_NONE = 2'b11;

endpackage : vend_pkg
`default_nettype wire

// File: rtl/vend_timeout_timer.sv
`default_nettype none
// ============================================================================
//  Module   : vend_timeout_timer
//  Brief    : Inactivity counter with clear, enable and terminal-count flag.
//  Revision : 1.0 - initial release
// ============================================================================
module vend_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int c_width = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_width-1:0] c_last = c_width'(TIMEOUT_CYCLES - 1);

    logic [c_width-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = i_enable && (r_count == c_last);

endmodule : vend_timeout_timer
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
//  Module   : vend_controller
//  Brief    : Coin credit / selection / vend / change transaction FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE1         = 15,
    parameter int PRICE2         = 20,
    parameter int PRICE3         = 25,
    parameter int MAX_CREDIT     = 100,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                select_valid,
    input  logic [1:0]          select_code,
    input  logic                cancel,
    input  logic [3:0]          prod1_count,
    input  logic [3:0]          prod2_count,
    input  logic [3:0]          prod3_count,
    output logic [1:0]          product_sel,
    output logic                update_inventory,
    output logic                dispense,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_out,
    output logic                coin_reject,
    output logic                sold_out,
    output logic                insufficient,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W:0] c_max_credit = MAX_CREDIT[CREDIT_W:0];

    state_t                r_state, w_state_n;
    logic [CREDIT_W-1:0]   r_credit, w_credit_n, r_change_out;
    logic [1:0]            r_sel, w_sel_n;
    logic                  r_change_valid;
    logic [CREDIT_W-1:0]   w_coin_val;
    logic [CREDIT_W:0]     w_sum;
    logic                  w_coin_ok;
    logic [3:0]            w_count;
    logic                  w_timeout;
    logic                  w_coin_reject, w_sold_out, w_insufficient;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] code);
        case (code)
            PROD1:   price_of = CREDIT_W'(PRICE1);
            PROD2:   price_of = CREDIT_W'(PRICE2);
            PROD3:   price_of = CREDIT_W'(PRICE3);
            default: price_of = '0;
        endcase
    endfunction

    always_comb begin
        w_coin_val = '0;
        case (coin_type)
            COIN_5:  w_coin_val = COIN_5_VAL;
            COIN_10: w_coin_val = COIN_10_VAL;
            COIN_25: w_coin_val = COIN_25_VAL;
            default: w_coin_val = '0;
        endcase
    end

    always_comb begin
        w_count = '0;
        case (select_code)
            PROD1:   w_count = prod1_count;
            PROD2:   w_count = prod2_count;
            PROD3:   w_count = prod3_count;
            default: w_count = '0;
        endcase
    end

    // 9-bit sum so an over-limit coin can never wrap into an acceptable value
    assign w_sum     = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_ok = coin_valid && (coin_type != COIN_BAD) && (w_sum <= c_max_credit);

    vend_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    ((r_state != S_CREDIT) || coin_valid || select_valid || cancel),
        .i_enable   (r_state == S_CREDIT),
        .o_terminal (w_timeout)
    );

    always_comb begin
        w_state_n      = r_state;
        w_credit_n     = r_credit;
        w_sel_n        = r_sel;
        w_coin_reject  = 1'b0;
        w_sold_out     = 1'b0;
        w_insufficient = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_coin_ok) begin
                    w_credit_n = w_sum[CREDIT_W-1:0];
                    w_state_n  = S_CREDIT;
                end else if (coin_valid) begin
                    w_coin_reject = 1'b1;
                end
            end
            S_CREDIT: begin
                if (cancel) begin
                    w_state_n     = S_CHANGE;
                    w_coin_reject = coin_valid;
                end else if (select_valid && (select_code != PROD_NONE) &&
                             (w_count != 4'd0) && (r_credit >= price_of(select_code))) begin
                    w_sel_n       = select_code;
                    w_state_n     = S_VEND;
                    w_coin_reject = coin_valid;
                end else begin
                    if (select_valid && (select_code != PROD_NONE)) begin
                        w_sold_out     = (w_count == 4'd0);
                        w_insufficient = (w_count != 4'd0);
                    end
                    if (w_coin_ok) begin
                        w_credit_n = w_sum[CREDIT_W-1:0];
                    end else if (coin_valid) begin
                        w_coin_reject = 1'b1;
                    end
                    if (w_timeout && !coin_valid && !select_valid) begin
                        w_state_n = S_CHANGE;
                    end
                end
            end
            S_VEND: begin
                w_credit_n    = r_credit - price_of(r_sel);
                w_state_n     = S_CHANGE;
                w_coin_reject = coin_valid;
            end
            S_CHANGE: begin
                w_credit_n    = '0;
                w_state_n     = S_IDLE;
                w_coin_reject = coin_valid;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_sel          <= PROD1;
            r_change_out   <= '0;
            r_change_valid <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_credit       <= w_credit_n;
            r_sel          <= w_sel_n;
            r_change_valid <= (w_state_n == S_CHANGE) && (w_credit_n != '0);
            if (w_state_n == S_CHANGE) begin
                r_change_out <= w_credit_n;
            end
        end
    end

    assign product_sel      = r_sel;
    assign update_inventory = (r_state == S_VEND);
    assign dispense         = (r_state == S_VEND);
    assign change_valid     = r_change_valid;
    assign change_out       = r_change_out;
    assign coin_reject      = w_coin_reject;
    assign sold_out         = w_sold_out;
    assign insufficient     = w_insufficient;
    assign credit           = r_credit;

endmodule : vend_controller
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vend_controller
//  Brief    : Directed self-checking bench for vend_controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       select_valid;
    logic [1:0] select_code;
    logic       cancel;
    logic [3:0] prod1_count, prod2_count, prod3_count;
    logic [1:0] product_sel;
    logic       update_inventory, dispense, change_valid;
    logic [7:0] change_out;
    logic       coin_reject, sold_out, insufficient;
    logic [7:0] credit;

    int checks   = 0;
    int failures = 0;

    vend_controller #(
        .PRICE1         (15),
        .PRICE2         (20),
        .PRICE3         (25),
        .MAX_CREDIT     (100),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .coin_valid       (coin_valid),
        .coin_type        (coin_type),
        .select_valid     (select_valid),
        .select_code      (select_code),
        .cancel           (cancel),
        .prod1_count      (prod1_count),
        .prod2_count      (prod2_count),
        .prod3_count      (prod3_count),
        .product_sel      (product_sel),
        .update_inventory (update_inventory),
        .dispense         (dispense),
        .change_valid     (change_valid),
        .change_out       (change_out),
        .coin_reject      (coin_reject),
        .sold_out         (sold_out),
        .insufficient     (insufficient),
        .credit           (credit)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        cyc();
        coin_valid = 1'b0;
    endtask

    task automatic do_select(input logic [1:0] c);
        select_valid = 1'b1;
        select_code  = c;
        cyc();
        select_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (credit !== 8'd0) begin failures++; $display("FAIL reset_credit got=%0d exp=0", credit); end
        checks++; if (product_sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", product_sel); end
        checks++; if ({update_inventory, dispense, change_valid, coin_reject, sold_out, insufficient} !== 6'b0)
            begin failures++; $display("FAIL reset_strobes got=%b exp=000000",
                {update_inventory, dispense, change_valid, coin_reject, sold_out, insufficient}); end
        checks++; if (change_out !== 8'd0) begin failures++; $display("FAIL reset_change_out got=%0d exp=0", change_out); end
    endtask

    task automatic test_vend_change();
        do_coin(2'b10);
        do_coin(2'b10);
        checks++; if (credit !== 8'd50) begin failures++; $display("FAIL vc_credit got=%0d exp=50", credit); end
        do_select(2'b00);
        checks++; if ({update_inventory, dispense} !== 2'b11) begin failures++; $display("FAIL vc_update got=%b exp=11", {update_inventory, dispense}); end
        checks++; if (product_sel !== 2'd0) begin failures++; $display("FAIL vc_sel got=%0d exp=0", product_sel); end
        checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL vc_early_change got=%b exp=0", change_valid); end
        cyc();
        checks++; if (change_valid !== 1'b1) begin failures++; $display("FAIL vc_change_valid got=%b exp=1", change_valid); end
        checks++; if (change_out !== 8'd35) begin failures++; $display("FAIL vc_change_out got=%0d exp=35", change_out); end
        checks++; if (update_inventory !== 1'b0) begin failures++; $display("FAIL vc_update_once got=%b exp=0", update_inventory); end
        cyc();
        checks++; if (credit !== 8'd0) begin failures++; $display("FAIL vc_credit_clear got=%0d exp=0", credit); end
        checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL vc_change_pulse got=%b exp=0", change_valid); end
    endtask

    task automatic test_sold_out();
        do_coin(2'b10);
        select_valid = 1'b1;
        select_code  = 2'b01;
        #1;
        checks++; if ({sold_out, insufficient} !== 2'b10) begin failures++; $display("FAIL so_strobe got=%b exp=10", {sold_out, insufficient}); end
        cyc();
        select_valid = 1'b0;
        checks++; if (update_inventory !== 1'b0) begin failures++; $display("FAIL so_no_update got=%b exp=0", update_inventory); end
        checks++; if (credit !== 8'd25) begin failures++; $display("FAIL so_credit got=%0d exp=25", credit); end
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        checks++; if ({change_valid, change_out} !== {1'b1, 8'd25}) begin failures++; $display("FAIL so_refund got=%b/%0d exp=1/25", change_valid, change_out); end
        cyc();
    endtask

    task automatic test_insufficient();
        do_coin(2'b00);
        select_valid = 1'b1;
        select_code  = 2'b10;
        #1;
        checks++; if ({sold_out, insufficient} !== 2'b01) begin failures++; $display("FAIL ins_strobe got=%b exp=01", {sold_out, insufficient}); end
        cyc();
        select_valid = 1'b0;
        do_coin(2'b01);
        do_coin(2'b01);
        checks++; if (credit !== 8'd25) begin failures++; $display("FAIL ins_credit got=%0d exp=25", credit); end
        do_select(2'b10);
        checks++; if ({update_inventory, product_sel} !== {1'b1, 2'b10}) begin failures++; $display("FAIL ins_vend got=%b/%0d exp=1/2", update_inventory, product_sel); end
        cyc();
        checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL ins_exact_change got=%b exp=0", change_valid); end
        cyc();
        checks++; if (credit !== 8'd0) begin failures++; $display("FAIL ins_idle_credit got=%0d exp=0", credit); end
        checks++; if (product_sel !== 2'b10) begin failures++; $display("FAIL ins_sel_hold got=%0d exp=2", product_sel); end
    endtask

    task automatic test_max_credit();
        for (int i = 0; i < 4; i++) do_coin(2'b10);
        checks++; if (credit !== 8'd100) begin failures++; $display("FAIL max_credit got=%0d exp=100", credit); end
        coin_valid = 1'b1;
        coin_type  = 2'b00;
        #1;
        checks++; if (coin_reject !== 1'b1) begin failures++; $display("FAIL max_reject got=%b exp=1", coin_reject); end
        cyc();
        checks++; if (credit !== 8'd100) begin failures++; $display("FAIL max_hold got=%0d exp=100", credit); end
        coin_type = 2'b11;
        #1;
        checks++; if (coin_reject !== 1'b1) begin failures++; $display("FAIL bad_coin_reject got=%b exp=1", coin_reject); end
        cyc();
        coin_valid = 1'b0;
        checks++; if (credit !== 8'd100) begin failures++; $display("FAIL bad_coin_credit got=%0d exp=100", credit); end
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        checks++; if (change_out !== 8'd100) begin failures++; $display("FAIL max_refund got=%0d exp=100", change_out); end
        cyc();
    endtask

    task automatic test_coin_with_select();
        do_coin(2'b10);
        coin_valid   = 1'b1;
        coin_type    = 2'b01;
        select_valid = 1'b1;
        select_code  = 2'b00;
        #1;
        checks++; if (coin_reject !== 1'b1) begin failures++; $display("FAIL cws_reject got=%b exp=1", coin_reject); end
        cyc();
        coin_valid   = 1'b0;
        select_valid = 1'b0;
        checks++; if (update_inventory !== 1'b1) begin failures++; $display("FAIL cws_update got=%b exp=1", update_inventory); end
        checks++; if (credit !== 8'd25) begin failures++; $display("FAIL cws_credit got=%0d exp=25", credit); end
        cyc();
        checks++; if ({change_valid, change_out} !== {1'b1, 8'd10}) begin failures++; $display("FAIL cws_change got=%b/%0d exp=1/10", change_valid, change_out); end
        cyc();
    endtask

    task automatic test_timeout();
        int n;
        do_coin(2'b01);
        n = 0;
        while (change_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        checks++; if (n !== 8) begin failures++; $display("FAIL to_cycles got=%0d exp=8", n); end
        checks++; if (change_out !== 8'd10) begin failures++; $display("FAIL to_refund got=%0d exp=10", change_out); end
        cyc();
        checks++; if (credit !== 8'd0) begin failures++; $display("FAIL to_credit got=%0d exp=0", credit); end
    endtask

    task automatic test_reset_in_vend();
        do_coin(2'b10);
        do_select(2'b10);
        checks++; if (update_inventory !== 1'b1) begin failures++; $display("FAIL rv_in_vend got=%b exp=1", update_inventory); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if ({update_inventory, dispense, change_valid} !== 3'b000) begin failures++; $display("FAIL rv_strobes got=%b exp=000", {update_inventory, dispense, change_valid}); end
        checks++; if ({credit, product_sel, change_out} !== 18'd0) begin failures++; $display("FAIL rv_values got=%0d/%0d/%0d exp=0/0/0", credit, product_sel, change_out); end
        cyc();
        checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL rv_no_refund got=%b exp=0", change_valid); end
    endtask

    initial begin
        rst          = 1'b1;
        coin_valid   = 1'b0;
        coin_type    = 2'b00;
        select_valid = 1'b0;
        select_code  = 2'b00;
        cancel       = 1'b0;
        prod1_count  = 4'd10;
        prod2_count  = 4'd0;
        prod3_count  = 4'd5;
        cyc();
        cyc();
        rst = 1'b0;
        test_reset();
        test_vend_change();
        test_sold_out();
        test_insufficient();
        test_max_credit();
        test_coin_with_select();
        test_timeout();
        test_reset_in_vend();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vend_controller
`default_nettype wire
